// File: rtl/lif_pkg.sv
// lif_pkg: shared Q4.4 types, constants and saturation helper for the LIF datapath
package lif_pkg;
  typedef logic signed [7:0] q44_t;
  localparam int Q44_ONE = 16;
  localparam int Q44_MAX = 127;
  localparam int Q44_MIN = -128;
  function automatic q44_t sat8(input logic signed [31:0] v);
    return v > Q44_MAX ? q44_t'(Q44_MAX) : v < Q44_MIN ? q44_t'(Q44_MIN) : q44_t'(v);
  endfunction
endpackage

// File: rtl/lif_synapse_driver_if.sv
// lif_synapse_driver_if: spike, weight-write and current/counter signals of the synapse driver
interface lif_synapse_driver_if #(parameter int N_IN = 4) ();
  import lif_pkg::*;
  localparam int AW = $clog2(N_IN);
  logic            en;
  logic [N_IN-1:0] spk_in;
  logic            w_we;
  logic [AW-1:0]   w_addr;
  q44_t            w_data;
  logic            cnt_clr;
  q44_t            I_q4_4;
  logic [7:0]      evt_cnt;
  modport master (output en, spk_in, w_we, w_addr, w_data, cnt_clr, input I_q4_4, evt_cnt);
  modport slave (input en, spk_in, w_we, w_addr, w_data, cnt_clr, output I_q4_4, evt_cnt);
endinterface

// File: rtl/lif_weight_bank.sv
// lif_weight_bank: N_IN x Q4.4 weight registers, sync write, all weights read in parallel
module lif_weight_bank
  import lif_pkg::*;
#(
  parameter int   N_IN    = 4,
  parameter q44_t W_RESET = 8'sd16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [$clog2(N_IN)-1:0] addr_i,
  input  q44_t                    data_i,
  output q44_t [N_IN-1:0]         w_o
);
  q44_t [N_IN-1:0] w_q;
  assign w_o = w_q;
  // reset loads the default weight everywhere; out-of-range addresses are dropped
  always_ff @(posedge clk) begin
    if (rst) w_q <= {N_IN{W_RESET}};
    else if (we_i && 32'(addr_i) < N_IN) w_q[addr_i] <= data_i;
  end
endmodule

// File: rtl/lif_synapse_driver.sv
// lif_synapse_driver: weighted spike sum into a decaying saturating Q4.4 current plus event counter
module lif_synapse_driver
  import lif_pkg::*;
#(
  parameter int   N_IN         = 4,
  parameter int   TAU_SH       = 2,
  parameter q44_t W_RESET_Q4_4 = 8'sd16
) (
  input logic clk,
  input logic rst,
  lif_synapse_driver_if.slave bus
);
  localparam int SW = 8 + $clog2(N_IN) + 1;
  q44_t [N_IN-1:0]    w;
  logic signed [SW-1:0] sum;
  logic signed [SW:0]   nxt;
  logic [8:0]           pc, cs;
  q44_t                 i_q, i_d;
  logic [7:0]           evt_q, evt_d;
  lif_weight_bank #(.N_IN(N_IN), .W_RESET(W_RESET_Q4_4)) u_bank (
    .clk(clk), .rst(rst), .we_i(bus.w_we), .addr_i(bus.w_addr), .data_i(bus.w_data), .w_o(w)
  );
  // weighted spike sum and popcount over the current (pre-write) weights
  always_comb begin
    sum = '0;
    pc = '0;
    for (int k = 0; k < N_IN; k++) begin
      sum = sum + (bus.spk_in[k] ? SW'(w[k]) : '0);
      pc = pc + 9'(bus.spk_in[k]);
    end
    nxt = (SW+1)'(i_q) - (SW+1)'(i_q >>> TAU_SH) + (SW+1)'(sum);
    cs = 9'(evt_q) + pc;
    i_d = bus.en ? sat8(32'(nxt)) : i_q;
    evt_d = bus.cnt_clr ? 8'd0 : bus.en ? (cs[8] ? 8'd255 : cs[7:0]) : evt_q;
  end
  // current and event counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      evt_q <= '0;
    end else begin
      i_q <= i_d;
      evt_q <= evt_d;
    end
  end
  assign bus.I_q4_4 = i_q;
  assign bus.evt_cnt = evt_q;
endmodule

// File: tb/tb_lif_synapse_driver.sv
// tb_lif_synapse_driver: directed vectors with hand-computed current and counter values
module tb_lif_synapse_driver;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_bad = 0;
  lif_synapse_driver_if #(.N_IN(4)) bus ();
  lif_synapse_driver #(.N_IN(4), .TAU_SH(2), .W_RESET_Q4_4(8'sd16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.en = 0; bus.spk_in = '0; bus.w_we = 0; bus.w_addr = '0; bus.w_data = '0; bus.cnt_clr = 0;
  endtask
  task automatic do_reset();
    idle();
    rst = 1;
    step();
    rst = 0;
  endtask
  int dec_seq[9] = '{16, 12, 9, 7, 6, 5, 4, 3, 3};
  int neg_seq[5] = '{-128, -128, -96, -72, -54};
  initial begin
    do_reset();
    chk("rst_I", int'(bus.I_q4_4), 0);
    chk("rst_evt", int'(bus.evt_cnt), 0);
    bus.en = 1;
    for (int i = 0; i < 9; i++) begin
      bus.spk_in = (i == 0) ? 4'b0001 : 4'b0000;
      step();
      chk($sformatf("decay%0d", i), int'(bus.I_q4_4), dec_seq[i]);
    end
    chk("evt_one", int'(bus.evt_cnt), 1);
    bus.en = 0;
    bus.spk_in = 4'b0000;
    for (int a = 0; a < 4; a++) begin
      bus.w_we = 1; bus.w_addr = 2'(a); bus.w_data = 8'sd127;
      step();
    end
    bus.w_we = 0;
    chk("wr_hold_I", int'(bus.I_q4_4), 3);
    bus.en = 1; bus.spk_in = 4'b1111;
    step();
    chk("satp0", int'(bus.I_q4_4), 127);
    step();
    chk("satp1", int'(bus.I_q4_4), 127);
    chk("evt_nine", int'(bus.evt_cnt), 9);
    do_reset();
    bus.w_we = 1; bus.w_addr = 0; bus.w_data = -8'sd128;
    step();
    bus.w_we = 0;
    bus.en = 1;
    for (int i = 0; i < 5; i++) begin
      bus.spk_in = (i < 2) ? 4'b0001 : 4'b0000;
      step();
      chk($sformatf("neg%0d", i), int'(bus.I_q4_4), neg_seq[i]);
    end
    do_reset();
    bus.en = 1; bus.spk_in = 4'b0001;
    bus.w_we = 1; bus.w_addr = 0; bus.w_data = 8'sd48;
    step();
    chk("coll_old", int'(bus.I_q4_4), 16);
    bus.w_we = 0;
    step();
    chk("coll_new", int'(bus.I_q4_4), 60);
    bus.en = 0; bus.spk_in = 4'b1111;
    step();
    chk("en0_I", int'(bus.I_q4_4), 60);
    chk("en0_evt", int'(bus.evt_cnt), 2);
    bus.en = 1;
    for (int i = 0; i < 70; i++) step();
    chk("evt_sat", int'(bus.evt_cnt), 255);
    step();
    chk("evt_hold", int'(bus.evt_cnt), 255);
    bus.cnt_clr = 1;
    step();
    chk("evt_clr", int'(bus.evt_cnt), 0);
    bus.cnt_clr = 0;
    step();
    chk("evt_after_clr", int'(bus.evt_cnt), 4);
    bus.en = 0; bus.cnt_clr = 1;
    step();
    chk("evt_clr_en0", int'(bus.evt_cnt), 0);
    bus.cnt_clr = 0;
    bus.en = 1; bus.spk_in = 4'b1111;
    step();
    bus.w_we = 1; bus.w_addr = 1; bus.w_data = 8'sd99;
    rst = 1;
    step();
    rst = 0;
    chk("mid_rst_I", int'(bus.I_q4_4), 0);
    chk("mid_rst_evt", int'(bus.evt_cnt), 0);
    idle();
    bus.en = 1; bus.spk_in = 4'b0001;
    step();
    chk("mid_rst_w0", int'(bus.I_q4_4), 16);
    bus.spk_in = 4'b0010;
    step();
    chk("mid_rst_w1", int'(bus.I_q4_4), 28);
    bus.spk_in = 4'b1000;
    step();
    chk("mid_rst_w3", int'(bus.I_q4_4), 37);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
